// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Lets two issuing stages share one combinational 64-bit ALU. Each cycle at
//   most one request is granted, chosen round-robin. The ALU sits outside this
//   block. The granted request's operands drive the ALU in the same cycle, and
//   the ALU result is captured into that requester's 1-entry response register.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   reqK_valid_i/ready_o       K=0,1 request handshake (ready == grant)
//   reqK_op_i/a_i/b_i/tag_i    K=0,1 ALUCtrl code, operands, tag
//   rspK_valid_o/ready_i       K=0,1 response handshake
//   rspK_data_o/tag_o/err_o    K=0,1 result, echoed tag, unsupported-op flag
//   alu_in1_o/in2_o/ctrl_o     drive to the shared ALU (0 when idle)
//   alu_result_i               combinational ALU result
//   grant_cnt_o                total grants, wraps silently
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [CTRL_W-1:0] req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic [TAG_W-1:0]  req0_tag_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [CTRL_W-1:0] req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    input  logic [TAG_W-1:0]  req1_tag_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_data_o,
    output logic [TAG_W-1:0]  rsp0_tag_o,
    output logic              rsp0_err_o,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_data_o,
    output logic [TAG_W-1:0]  rsp1_tag_o,
    output logic              rsp1_err_o,
    output logic [DATA_W-1:0] alu_in1_o,
    output logic [DATA_W-1:0] alu_in2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic [CNT_W-1:0]  grant_cnt_o
);

    logic              rsp0_valid_r, rsp1_valid_r;
    logic [DATA_W-1:0] rsp0_data_r, rsp1_data_r;
    logic [TAG_W-1:0]  rsp0_tag_r, rsp1_tag_r;
    logic              rsp0_err_r, rsp1_err_r;
    logic [CNT_W-1:0]  grant_cnt_r;
    logic              last_grant_r;   // 1 = req1 was granted last

    logic elig0_s, elig1_s;
    logic grant0_s, grant1_s;

    // A request is eligible if its response slot is empty or drains this cycle
    always_comb begin
        elig0_s = req0_valid_i && (!rsp0_valid_r || rsp0_ready_i);
        elig1_s = req1_valid_i && (!rsp1_valid_r || rsp1_ready_i);
    end

    // Round-robin pick: on a tie the requester not granted last time wins
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (elig0_s && elig1_s) begin
            grant0_s = last_grant_r;
            grant1_s = !last_grant_r;
        end else begin
            grant0_s = elig0_s;
            grant1_s = elig1_s;
        end
    end

    // Route the winner's operands to the ALU; hold the ALU inputs at zero when idle
    always_comb begin
        alu_in1_o  = {DATA_W{1'b0}};
        alu_in2_o  = {DATA_W{1'b0}};
        alu_ctrl_o = {CTRL_W{1'b0}};
        if (grant0_s) begin
            alu_in1_o  = req0_a_i;
            alu_in2_o  = req0_b_i;
            alu_ctrl_o = req0_op_i;
        end else if (grant1_s) begin
            alu_in1_o  = req1_a_i;
            alu_in2_o  = req1_b_i;
            alu_ctrl_o = req1_op_i;
        end else begin
            alu_in1_o  = {DATA_W{1'b0}};
            alu_in2_o  = {DATA_W{1'b0}};
            alu_ctrl_o = {CTRL_W{1'b0}};
        end
    end

    // Arbitration history and total grant counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_r <= 1'b1;
            grant_cnt_r  <= {CNT_W{1'b0}};
        end else if (grant0_s || grant1_s) begin
            last_grant_r <= grant1_s;
            grant_cnt_r  <= grant_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            last_grant_r <= last_grant_r;
            grant_cnt_r  <= grant_cnt_r;
        end
    end

    // Response slot 0: a new grant overrides a same-cycle drain (no bubble)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp0_valid_r <= 1'b0;
            rsp0_data_r  <= {DATA_W{1'b0}};
            rsp0_tag_r   <= {TAG_W{1'b0}};
            rsp0_err_r   <= 1'b0;
        end else if (grant0_s) begin
            rsp0_valid_r <= 1'b1;
            rsp0_data_r  <= alu_result_i;
            rsp0_tag_r   <= req0_tag_i;
            rsp0_err_r   <= req0_op_i[CTRL_W-1];
        end else if (rsp0_ready_i) begin
            rsp0_valid_r <= 1'b0;
        end else begin
            rsp0_valid_r <= rsp0_valid_r;
        end
    end

    // Response slot 1: same policy as slot 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp1_valid_r <= 1'b0;
            rsp1_data_r  <= {DATA_W{1'b0}};
            rsp1_tag_r   <= {TAG_W{1'b0}};
            rsp1_err_r   <= 1'b0;
        end else if (grant1_s) begin
            rsp1_valid_r <= 1'b1;
            rsp1_data_r  <= alu_result_i;
            rsp1_tag_r   <= req1_tag_i;
            rsp1_err_r   <= req1_op_i[CTRL_W-1];
        end else if (rsp1_ready_i) begin
            rsp1_valid_r <= 1'b0;
        end else begin
            rsp1_valid_r <= rsp1_valid_r;
        end
    end

    // Output mapping: the response fields come straight from their registers
    always_comb begin
        req0_ready_o = grant0_s;
        req1_ready_o = grant1_s;
        rsp0_valid_o = rsp0_valid_r;
        rsp0_data_o  = rsp0_data_r;
        rsp0_tag_o   = rsp0_tag_r;
        rsp0_err_o   = rsp0_err_r;
        rsp1_valid_o = rsp1_valid_r;
        rsp1_data_o  = rsp1_data_r;
        rsp1_tag_o   = rsp1_tag_r;
        rsp1_err_o   = rsp1_err_r;
        grant_cnt_o  = grant_cnt_r;
    end

endmodule
